// File: rtl/cpu_control_package.sv
// Shared encodings for the RV32 multi-cycle control sequencer.
package cpu_control_package;

    typedef enum logic [6:0] {
        LOAD     = 7'b0000011,
        MISC_MEM = 7'b0001111,
        OP_IMM   = 7'b0010011,
        AUIPC    = 7'b0010111,
        STORE    = 7'b0100011,
        OP       = 7'b0110011,
        LUI      = 7'b0110111,
        BRANCH   = 7'b1100011,
        JALR     = 7'b1100111,
        JAL      = 7'b1101111,
        SYSTEM   = 7'b1110011
    } opcode_type_t;

    typedef enum logic [2:0] {
        R_TYPE, I_TYPE, S_TYPE, B_TYPE, U_TYPE, J_TYPE
    } instruction_type_t;

    localparam logic [2:0] LW = 3'b010;
    localparam logic [2:0] SW = 3'b010;

    typedef enum logic [2:0] {
        FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, TRAP
    } seq_state_t;

    typedef enum logic [1:0] {
        NONE, ILLEGAL, IMEM_TIMEOUT, DMEM_TIMEOUT
    } trap_cause_t;

    typedef enum logic [2:0] {
        CL_LOAD, CL_STORE, CL_OP, CL_OP_IMM, CL_BRANCH
    } instr_class_t;

    typedef struct packed {
        logic         legal;
        instr_class_t cls;
    } decode_t;

    // Classify an instruction; anything outside the supported subset is illegal.
    function automatic decode_t decode_instr(input logic [6:0] opcode, input logic [2:0] funct3);
        decode_t d;
        d.legal = 1'b0;
        d.cls   = CL_OP;
        case (opcode)
            LOAD:    begin d.cls = CL_LOAD;   d.legal = (funct3 == LW); end
            STORE:   begin d.cls = CL_STORE;  d.legal = (funct3 == SW); end
            OP_IMM:  begin d.cls = CL_OP_IMM; d.legal = 1'b1; end
            OP:      begin d.cls = CL_OP;     d.legal = 1'b1; end
            BRANCH:  begin d.cls = CL_BRANCH; d.legal = (funct3 != 3'd2) && (funct3 != 3'd3); end
            default: ;
        endcase
        return d;
    endfunction

    // Immediate format the immediate generator needs for each class.
    function automatic instruction_type_t class_to_type(input instr_class_t cls);
        case (cls)
            CL_LOAD, CL_OP_IMM: return I_TYPE;
            CL_STORE:           return S_TYPE;
            CL_BRANCH:          return B_TYPE;
            default:            return R_TYPE;
        endcase
    endfunction

endpackage

// File: rtl/seq_wait_timer.sv
// Wait-cycle counter shared by the FETCH and MEMORY handshakes.
module seq_wait_timer #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int TIMEOUT_W = $clog2(MEM_TIMEOUT + 1);

    logic [TIMEOUT_W-1:0] count;

    // Count stalled cycles; a state change restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    // This stalled cycle is the last one allowed; a ready arriving now still wins upstream.
    assign expired = enable && (count == TIMEOUT_W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/cpu_control_sequencer.sv
// Multi-cycle control FSM: FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, TRAP.
module cpu_control_sequencer
    import cpu_control_package::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [6:0]        opcode,
    input  logic [2:0]        funct3,
    input  logic              branch_taken,
    output logic              imem_req,
    input  logic              imem_ready,
    output logic              dmem_req,
    output logic              dmem_we,
    input  logic              dmem_ready,
    output logic              ir_write,
    output logic              pc_write,
    output logic              pc_src,
    output logic              reg_write,
    output logic              alu_select,
    output logic              result_select,
    output instruction_type_t instruction_type,
    output logic              retire,
    output logic              trap,
    output trap_cause_t       trap_cause
);
    seq_state_t   state, state_next;
    trap_cause_t  cause_q, cause_next;
    instr_class_t cls_q, cls_view;
    decode_t      dec;
    logic         started_q;
    logic         in_body;
    logic         ready_now;
    logic         timer_clear;
    logic         timer_enable;
    logic         timer_expired;

    assign dec       = decode_instr(opcode, funct3);
    // DECODE shows the fresh decode so the class is visible from DECODE through WRITEBACK.
    assign cls_view  = (state == DECODE) ? dec.cls : cls_q;
    assign in_body   = (state == DECODE) || (state == EXECUTE) || (state == MEMORY) || (state == WRITEBACK);
    assign ready_now = (state == FETCH) ? imem_ready : dmem_ready;

    // started_q keeps requests low in the cycle reset is released, so fetch begins one cycle later.
    assign timer_enable = started_q && ((state == FETCH) || (state == MEMORY)) && !ready_now;
    assign timer_clear  = (state_next != state);

    seq_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .expired (timer_expired)
    );

    // State, decoded class and trap cause registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: only control state is reset here; reset pulls every output low without extra gating.
        if (!rst_n) begin
            state     <= FETCH;
            cls_q     <= CL_OP;
            cause_q   <= NONE;
            started_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples values from before the edge.
            started_q <= 1'b1;
            state     <= state_next;
            cause_q   <= cause_next;
            if (state == DECODE) begin
                cls_q <= dec.cls;
            end
        end
    end

    // Next-state and datapath control decode.
    always_comb begin
        // NOTE: every output and next-state value gets a default first, so no path infers a latch.
        state_next       = state;
        cause_next       = cause_q;
        imem_req         = 1'b0;
        dmem_req         = 1'b0;
        dmem_we          = 1'b0;
        ir_write         = 1'b0;
        pc_write         = 1'b0;
        pc_src           = 1'b0;
        reg_write        = 1'b0;
        retire           = 1'b0;
        instruction_type = class_to_type(cls_view);
        alu_select       = in_body && (cls_view inside {CL_LOAD, CL_STORE, CL_OP_IMM});
        result_select    = in_body && (cls_view == CL_LOAD);

        case (state)
            FETCH: begin
                if (started_q) begin
                    imem_req = 1'b1;
                    if (imem_ready) begin
                        ir_write   = 1'b1;
                        state_next = DECODE;
                    end else if (timer_expired) begin
                        state_next = TRAP;
                        cause_next = IMEM_TIMEOUT;
                    end
                end
            end
            DECODE: begin
                if (dec.legal) begin
                    state_next = EXECUTE;
                end else begin
                    state_next = TRAP;
                    cause_next = ILLEGAL;
                end
            end
            EXECUTE: begin
                case (cls_view)
                    CL_BRANCH: begin
                        pc_write   = 1'b1;
                        pc_src     = branch_taken;
                        retire     = 1'b1;
                        state_next = FETCH;
                    end
                    CL_LOAD, CL_STORE: state_next = MEMORY;
                    default:           state_next = WRITEBACK;
                endcase
            end
            MEMORY: begin
                dmem_req = 1'b1;
                dmem_we  = (cls_view == CL_STORE);
                if (dmem_ready) begin
                    if (cls_view == CL_STORE) begin
                        pc_write   = 1'b1;
                        retire     = 1'b1;
                        state_next = FETCH;
                    end else begin
                        state_next = WRITEBACK;
                    end
                end else if (timer_expired) begin
                    state_next = TRAP;
                    cause_next = DMEM_TIMEOUT;
                end
            end
            WRITEBACK: begin
                reg_write  = 1'b1;
                pc_write   = 1'b1;
                retire     = 1'b1;
                state_next = FETCH;
            end
            TRAP:    ;
            default: state_next = TRAP;
        endcase
    end

    assign trap       = (state == TRAP);
    assign trap_cause = cause_q;

endmodule

// File: tb/tb_cpu_control_sequencer.sv
// Self-checking bench: per-instruction cycle scripts derived from the sequencing rules.
module tb_cpu_control_sequencer;
    import cpu_control_package::*;

    localparam int TMO = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [6:0]        opcode = '0;
    logic [2:0]        funct3 = '0;
    logic              branch_taken = 1'b0;
    logic              imem_ready = 1'b0;
    logic              dmem_ready = 1'b0;
    logic              imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_src;
    logic              reg_write, alu_select, result_select, retire, trap;
    instruction_type_t instruction_type;
    trap_cause_t       trap_cause;

    always #5 clk = ~clk;

    cpu_control_sequencer #(.MEM_TIMEOUT(TMO)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .opcode           (opcode),
        .funct3           (funct3),
        .branch_taken     (branch_taken),
        .imem_req         (imem_req),
        .imem_ready       (imem_ready),
        .dmem_req         (dmem_req),
        .dmem_we          (dmem_we),
        .dmem_ready       (dmem_ready),
        .ir_write         (ir_write),
        .pc_write         (pc_write),
        .pc_src           (pc_src),
        .reg_write        (reg_write),
        .alu_select       (alu_select),
        .result_select    (result_select),
        .instruction_type (instruction_type),
        .retire           (retire),
        .trap             (trap),
        .trap_cause       (trap_cause)
    );

    typedef struct packed {
        logic       imem_req;
        logic       dmem_req;
        logic       dmem_we;
        logic       ir_write;
        logic       pc_write;
        logic       pc_src;
        logic       reg_write;
        logic       alu_select;
        logic       result_select;
        logic [2:0] instruction_type;
        logic       retire;
        logic       trap;
        logic [1:0] trap_cause;
    } outs_t;

    typedef struct {
        logic [6:0] opcode;
        logic [2:0] funct3;
        int         fw;     // fetch wait cycles before imem_ready
        int         mw;     // memory wait cycles before dmem_ready
        logic       bt;
        string      name;
    } instr_t;

    typedef struct {
        logic [6:0] opcode;
        logic [2:0] funct3;
        logic       imem_ready;
        logic       dmem_ready;
        logic       branch_taken;
        outs_t      exp;
        outs_t      care;
        string      tag;
    } cyc_t;

    cyc_t   script[$];
    int     n_checks = 0;
    int     n_pass = 0;
    instr_t dir[14];

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic outs_t sample();
        outs_t s;
        s.imem_req         = imem_req;
        s.dmem_req         = dmem_req;
        s.dmem_we          = dmem_we;
        s.ir_write         = ir_write;
        s.pc_write         = pc_write;
        s.pc_src           = pc_src;
        s.reg_write        = reg_write;
        s.alu_select       = alu_select;
        s.result_select    = result_select;
        s.instruction_type = instruction_type;
        s.retire           = retire;
        s.trap             = trap;
        s.trap_cause       = trap_cause;
        return s;
    endfunction

    task automatic check(input string name, input outs_t exp, input outs_t care);
        outs_t act;
        act = sample();
        n_checks++;
        if (((act ^ exp) & care) == '0) n_pass++;
        else $display("FAIL %s: outputs got %h, required %h (mask %h) at %0t", name, act, exp, care, $time);
    endtask

    // Supported subset: LW, SW, any OP/OP_IMM, branches other than funct3 2 and 3.
    function automatic bit model_legal(input logic [6:0] op, input logic [2:0] f3);
        case (op)
            7'b0000011, 7'b0100011: return f3 == 3'b010;
            7'b0010011, 7'b0110011: return 1'b1;
            7'b1100011:             return (f3 != 3'd2) && (f3 != 3'd3);
            default:                return 1'b0;
        endcase
    endfunction

    task automatic push(input instr_t in, input logic ir, input logic dr, input logic bt,
                        input outs_t e, input outs_t c, input string phase);
        cyc_t cy;
        cy.opcode = in.opcode;  cy.funct3 = in.funct3;
        cy.imem_ready = ir;     cy.dmem_ready = dr;  cy.branch_taken = bt;
        cy.exp = e;             cy.care = c;
        cy.tag = $sformatf("%s/%s", in.name, phase);
        script.push_back(cy);
    endtask

    task automatic push_trap(input instr_t in, input logic [1:0] cause);
        outs_t e, c;
        e = '0; e.trap = 1'b1; e.trap_cause = cause;
        c = '1; c.instruction_type = '0;
        for (int i = 0; i < 3; i++) push(in, rb(), rb(), rb(), e, c, "trap");
    endtask

    // Expand one instruction into its expected cycle-by-cycle control pattern.
    task automatic build(input instr_t in, output bit trapped);
        outs_t e, c, body;
        bit    is_load, is_store, is_branch;
        int    n;
        trapped   = 1'b1;
        is_load   = (in.opcode == 7'b0000011);
        is_store  = (in.opcode == 7'b0100011);
        is_branch = (in.opcode == 7'b1100011);
        body = '0;
        body.alu_select    = is_load || is_store || (in.opcode == 7'b0010011);
        body.result_select = is_load;
        body.instruction_type = is_store ? 3'd2 : is_branch ? 3'd3 :
                                (in.opcode == 7'b0110011) ? 3'd0 : 3'd1;
        c = '1; c.instruction_type = '0;
        n = (in.fw >= TMO) ? TMO : in.fw;
        e = '0; e.imem_req = 1'b1;
        for (int i = 0; i < n; i++) push(in, 1'b0, rb(), rb(), e, c, "fetch_wait");
        if (in.fw >= TMO) begin push_trap(in, 2'd2); return; end
        e.ir_write = 1'b1;
        push(in, 1'b1, rb(), rb(), e, c, "fetch");
        c = '1;
        if (!model_legal(in.opcode, in.funct3)) begin
            c.alu_select = 1'b0; c.result_select = 1'b0; c.instruction_type = '0;
            push(in, rb(), rb(), rb(), '0, c, "decode");
            push_trap(in, 2'd1);
            return;
        end
        push(in, rb(), rb(), rb(), body, c, "decode");
        e = body;
        if (is_branch) begin
            e.pc_write = 1'b1; e.pc_src = in.bt; e.retire = 1'b1;
            push(in, rb(), rb(), in.bt, e, c, "execute");
            trapped = 1'b0;
            return;
        end
        push(in, rb(), rb(), rb(), e, c, "execute");
        if (is_load || is_store) begin
            n = (in.mw >= TMO) ? TMO : in.mw;
            e = body; e.dmem_req = 1'b1; e.dmem_we = is_store;
            for (int i = 0; i < n; i++) push(in, rb(), 1'b0, rb(), e, c, "mem_wait");
            if (in.mw >= TMO) begin push_trap(in, 2'd3); return; end
            if (is_store) begin e.pc_write = 1'b1; e.retire = 1'b1; end
            push(in, rb(), 1'b1, rb(), e, c, "mem");
            if (is_store) begin trapped = 1'b0; return; end
        end
        e = body; e.reg_write = 1'b1; e.pc_write = 1'b1; e.retire = 1'b1;
        push(in, rb(), rb(), rb(), e, c, "writeback");
        trapped = 1'b0;
    endtask

    task automatic play_n(input int n);
        cyc_t cy;
        for (int i = 0; i < n && script.size() > 0; i++) begin
            cy = script.pop_front();
            @(posedge clk); #1;
            opcode = cy.opcode; funct3 = cy.funct3;
            imem_ready = cy.imem_ready; dmem_ready = cy.dmem_ready; branch_taken = cy.branch_taken;
            @(negedge clk);
            check(cy.tag, cy.exp, cy.care);
        end
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; imem_ready = rb(); dmem_ready = rb();
        #1 check("reset_assert", '0, '1);
        @(negedge clk);
        check("reset_held", '0, '1);
        @(posedge clk); #1;
        rst_n = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b1;
        @(negedge clk);
        check("reset_release_idle", '0, '1);
    endtask

    task automatic run(input instr_t in);
        bit tr;
        build(in, tr);
        play_n(script.size());
        if (tr) apply_reset();
    endtask

    task automatic rand_instr(input int idx, output instr_t in);
        int k;
        k = $urandom_range(0, 99);
        in.fw = ($urandom_range(0, 39) == 0) ? TMO : $urandom_range(0, TMO - 1);
        in.mw = ($urandom_range(0, 39) == 0) ? TMO : $urandom_range(0, TMO - 1);
        in.bt = rb();
        in.funct3 = 3'($urandom_range(0, 7));
        in.name = $sformatf("rand%0d", idx);
        if (k < 8) begin
            in.opcode = 7'($urandom_range(0, 127));
        end else begin
            case (k % 5)
                0: in.opcode = 7'b0000011;
                1: in.opcode = 7'b0100011;
                2: in.opcode = 7'b0110011;
                3: in.opcode = 7'b0010011;
                default: in.opcode = 7'b1100011;
            endcase
            if ((k % 5) < 2 && k < 92) in.funct3 = 3'b010;
        end
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: run exceeded its time budget");
        $fatal(1, "bench did not complete");
    end

    initial begin : main
        outs_t  e, c;
        instr_t in;
        bit     tr;

        dir[0]  = '{7'b0110011, 3'b000, 0, 0, 1'b0, "op_add"};
        dir[1]  = '{7'b0000011, 3'b010, 0, 3, 1'b0, "lw_3wait"};
        dir[2]  = '{7'b0100011, 3'b010, 0, 0, 1'b0, "sw"};
        dir[3]  = '{7'b1100011, 3'b000, 0, 0, 1'b1, "beq_taken"};
        dir[4]  = '{7'b1100011, 3'b001, 2, 0, 1'b0, "bne_not_taken"};
        dir[5]  = '{7'b0010011, 3'b000, 1, 0, 1'b0, "addi"};
        dir[6]  = '{7'b0001111, 3'b000, 0, 0, 1'b0, "fence_illegal"};
        dir[7]  = '{7'b0000011, 3'b000, 0, 0, 1'b0, "lb_illegal"};
        dir[8]  = '{7'b1100011, 3'b010, 0, 0, 1'b0, "branch_f3_2_illegal"};
        dir[9]  = '{7'b0110011, 3'b000, TMO, 0, 1'b0, "imem_timeout"};
        dir[10] = '{7'b0110011, 3'b000, TMO - 1, 0, 1'b0, "imem_ready_last"};
        dir[11] = '{7'b0100011, 3'b010, 0, TMO - 1, 1'b0, "dmem_ready_last"};
        dir[12] = '{7'b0000011, 3'b010, 0, TMO, 1'b0, "dmem_timeout"};
        dir[13] = '{7'b0100011, 3'b001, 0, 0, 1'b0, "sh_illegal"};

        apply_reset();
        for (int i = 0; i < 14; i++) run(dir[i]);

        // Reset asserted while a load holds dmem_req high.
        in = '{7'b0000011, 3'b010, 0, TMO - 1, 1'b0, "lw_reset_mid_mem"};
        build(in, tr);
        play_n(5);
        #2 rst_n = 1'b0;
        #1 check("reset_mid_memory", '0, '1);
        script.delete();
        @(posedge clk); #1;
        rst_n = 1'b1; imem_ready = 1'b0; dmem_ready = 1'b1;
        @(negedge clk);
        check("after_mid_reset_idle", '0, '1);
        @(posedge clk); #1;
        imem_ready = 1'b0;
        @(negedge clk);
        e = '0; e.imem_req = 1'b1;
        c = '1; c.instruction_type = '0;
        check("after_mid_reset_fetch", e, c);
        apply_reset();

        for (int i = 0; i < 200; i++) begin
            rand_instr(i, in);
            run(in);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
